// File: rtl/prm_edge_scan_seq.sv
// Edge-check sequencer: walks NSAMP codes base + i*stride through the obstacle checker and folds edge_mask into a verdict.
// Optional feature macro: PRM_EDGE_EARLY_EXIT_EN (stop scanning at the first blocked sample).
module prm_edge_scan_seq #(
  parameter  int NSAMP = 16,
  parameter  int IDW   = 8,
  localparam int IW    = (NSAMP > 1) ? $clog2(NSAMP) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [14:0]    req_base,
  input  logic [14:0]    req_stride,
  input  logic [IDW-1:0] req_id,
  output logic [14:0]    chk_code,
  input  logic           chk_mask,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic           rsp_blocked,
  output logic [IW-1:0]  rsp_hit_idx,
  output logic [IW:0]    rsp_nblk
);

`ifdef PRM_EDGE_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [IW-1:0] LAST_IDX = IW'(NSAMP - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [14:0]    code_q, code_d;
  logic [14:0]    stride_q, stride_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [IDW-1:0] id_q, id_d;
  logic           blocked_q, blocked_d;
  logic [IW-1:0]  hit_q, hit_d;
  logic [IW:0]    nblk_q, nblk_d;
  logic           req_ready_q, req_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           exit_s;

  // State and datapath registers; handshake outputs are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      code_q      <= 15'd0;
      stride_q    <= 15'd0;
      idx_q       <= {IW{1'b0}};
      id_q        <= {IDW{1'b0}};
      blocked_q   <= 1'b0;
      hit_q       <= {IW{1'b0}};
      nblk_q      <= {(IW+1){1'b0}};
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      stride_q    <= stride_d;
      idx_q       <= idx_d;
      id_q        <= id_d;
      blocked_q   <= blocked_d;
      hit_q       <= hit_d;
      nblk_q      <= nblk_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Next-state, sample folding and code stepping.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    stride_d  = stride_q;
    idx_d     = idx_q;
    id_d      = id_q;
    blocked_d = blocked_q;
    hit_d     = hit_q;
    nblk_d    = nblk_q;
    exit_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d   = ST_SCAN;
          code_d    = req_base;
          stride_d  = req_stride;
          id_d      = req_id;
          idx_d     = {IW{1'b0}};
          blocked_d = 1'b0;
          hit_d     = {IW{1'b0}};
          nblk_d    = {(IW+1){1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (chk_mask) begin
          nblk_d    = nblk_q + (IW+1)'(1);
          blocked_d = 1'b1;
          if (!blocked_q) begin
            hit_d = idx_q;
          end else begin
            hit_d = hit_q;
          end
        end else begin
          nblk_d = nblk_q;
        end
        exit_s = (idx_q == LAST_IDX) || (EARLY_EXIT && chk_mask);
        // Code is frozen on exit so the last scanned sample stays on chk_code.
        if (exit_s) begin
          state_d = ST_DONE;
        end else begin
          code_d = code_q + stride_q;
          idx_d  = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_DONE);
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign chk_code    = code_q;
  assign rsp_id      = id_q;
  assign rsp_blocked = blocked_q;
  assign rsp_hit_idx = hit_q;
  assign rsp_nblk    = nblk_q;

endmodule

// File: tb/tb_prm_edge_scan_seq.sv
// Self-checking bench for prm_edge_scan_seq: checker lookup table drives chk_mask, a per-edge reference model predicts the verdict.
module tb_prm_edge_scan_seq;
  localparam int NSAMP = 16;
  localparam int IDW   = 8;
  localparam int IW    = $clog2(NSAMP);
`ifdef PRM_EDGE_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [14:0]    req_base = 15'd0;
  logic [14:0]    req_stride = 15'd0;
  logic [IDW-1:0] req_id = '0;
  logic [14:0]    chk_code;
  logic           chk_mask;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [IDW-1:0] rsp_id;
  logic           rsp_blocked;
  logic [IW-1:0]  rsp_hit_idx;
  logic [IW:0]    rsp_nblk;

  bit          blk_tbl [0:32767];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc_cnt = 0;
  int          accept_cyc = 0;
  logic [14:0] exp_codes [$];
  logic        exp_blk;
  int          exp_hit, exp_nblk, exp_lat;

  prm_edge_scan_seq #(.NSAMP(NSAMP), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_stride(req_stride), .req_id(req_id),
    .chk_code(chk_code), .chk_mask(chk_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_blocked(rsp_blocked), .rsp_hit_idx(rsp_hit_idx), .rsp_nblk(rsp_nblk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  assign chk_mask = blk_tbl[chk_code];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic clear_tbl();
    for (int i = 0; i < 32768; i++) blk_tbl[i] = 1'b0;
  endtask

  // Reference: walk the sample list with modular arithmetic and apply the fold rules.
  task automatic model(input logic [14:0] base, input logic [14:0] stride);
    int code;
    exp_codes.delete();
    exp_blk  = 1'b0;
    exp_hit  = 0;
    exp_nblk = 0;
    exp_lat  = NSAMP + 1;
    for (int i = 0; i < NSAMP; i++) begin
      code = (int'(base) + i * int'(stride)) % 32768;
      exp_codes.push_back(code[14:0]);
      if (blk_tbl[code]) begin
        if (!exp_blk) exp_hit = i;
        exp_blk = 1'b1;
        exp_nblk++;
        if (EARLY) begin
          exp_lat = i + 2;
          break;
        end
      end
    end
  endtask

  task automatic run_edge(input logic [14:0] base, input logic [14:0] stride,
                          input logic [IDW-1:0] id, input int hold);
    int c;
    int t;
    logic [14:0] last_code;
    model(base, stride);
    last_code = exp_codes[exp_codes.size() - 1];
    rsp_ready = (hold == 0);
    t = 0;
    while (req_ready !== 1'b1 && t < 4 * NSAMP) begin
      @(posedge clk); #1; t++;
    end
    n_chk++;
    if (req_ready !== 1'b1) $display("FAIL req_ready_wait: got %b want 1", req_ready);
    else n_pass++;
    req_base = base; req_stride = stride; req_id = id; req_valid = 1'b1;
    @(posedge clk); #1;
    accept_cyc = cyc_cnt;
    req_valid = 1'b0;
    c = 1;
    while (rsp_valid !== 1'b1 && c <= 3 * NSAMP) begin
      if (c - 1 < exp_codes.size()) begin
        n_chk++;
        if (chk_code !== exp_codes[c-1])
          $display("FAIL chk_code[%0d]: got %h want %h", c - 1, chk_code, exp_codes[c-1]);
        else n_pass++;
      end
      @(posedge clk); #1; c++;
    end
    n_chk++;
    if (c !== exp_lat) $display("FAIL rsp_latency: got %0d want %0d cycles", c, exp_lat);
    else n_pass++;
    for (int h = 0; h <= hold; h++) begin
      n_chk++;
      if (rsp_valid !== 1'b1) $display("FAIL rsp_valid_hold: got %b want 1 (cycle %0d)", rsp_valid, h);
      else n_pass++;
      n_chk++;
      if (rsp_id !== id) $display("FAIL rsp_id: got %h want %h", rsp_id, id);
      else n_pass++;
      n_chk++;
      if (rsp_blocked !== exp_blk) $display("FAIL rsp_blocked: got %b want %b", rsp_blocked, exp_blk);
      else n_pass++;
      n_chk++;
      if (rsp_hit_idx !== IW'(exp_hit)) $display("FAIL rsp_hit_idx: got %0d want %0d", rsp_hit_idx, exp_hit);
      else n_pass++;
      n_chk++;
      if (rsp_nblk !== (IW+1)'(exp_nblk)) $display("FAIL rsp_nblk: got %0d want %0d", rsp_nblk, exp_nblk);
      else n_pass++;
      n_chk++;
      if (req_ready !== 1'b0) $display("FAIL req_ready_in_done: got %b want 0", req_ready);
      else n_pass++;
      if (h == hold) begin
        rsp_ready = 1'b1;
      end else begin
        req_valid = 1'b1;
        req_base  = 15'h1234;
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (rsp_valid !== 1'b0) $display("FAIL rsp_valid_after_hs: got %b want 0", rsp_valid);
    else n_pass++;
    n_chk++;
    if (req_ready !== 1'b1) $display("FAIL req_ready_after_hs: got %b want 1", req_ready);
    else n_pass++;
    n_chk++;
    if (chk_code !== last_code) $display("FAIL chk_code_held: got %h want %h", chk_code, last_code);
    else n_pass++;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
  endtask

  task automatic test_reset();
    clear_tbl();
    #12;
    n_chk++;
    if ({req_ready, rsp_valid, chk_code, rsp_id, rsp_blocked, rsp_hit_idx, rsp_nblk} !==
        {1'b1, 1'b0, 15'd0, {IDW{1'b0}}, 1'b0, {IW{1'b0}}, {(IW+1){1'b0}}})
      $display("FAIL reset_values: got rdy=%b vld=%b code=%h id=%h blk=%b hit=%0d nblk=%0d want 1 0 0 0 0 0 0",
               req_ready, rsp_valid, chk_code, rsp_id, rsp_blocked, rsp_hit_idx, rsp_nblk);
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_free_edge();
    clear_tbl();
    run_edge(15'h0100, 15'h0001, 8'h11, 0);
  endtask

  task automatic test_blocked_edge();
    clear_tbl();
    blk_tbl[15'h0016] = 1'b1;
    blk_tbl[15'h001C] = 1'b1;
    run_edge(15'h0010, 15'h0002, 8'h22, 0);
  endtask

  task automatic test_wrap();
    clear_tbl();
    run_edge(15'h7FFE, 15'h0001, 8'h33, 0);
  endtask

  task automatic test_backpressure();
    clear_tbl();
    blk_tbl[15'h0016] = 1'b1;
    blk_tbl[15'h001C] = 1'b1;
    run_edge(15'h0010, 15'h0002, 8'h44, 10);
  endtask

  task automatic test_reset_mid_scan();
    int stale;
    clear_tbl();
    req_base = 15'h0500; req_stride = 15'h0003; req_id = 8'h5A; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    n_chk++;
    if (chk_code !== 15'h050F) $display("FAIL mid_scan_code: got %h want 050f", chk_code);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({rsp_valid, chk_code, req_ready, rsp_id, rsp_nblk} !== {1'b0, 15'd0, 1'b1, {IDW{1'b0}}, {(IW+1){1'b0}}})
      $display("FAIL reset_mid_scan: got vld=%b code=%h rdy=%b id=%h nblk=%0d want 0 0 1 0 0",
               rsp_valid, chk_code, req_ready, rsp_id, rsp_nblk);
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 3 * NSAMP; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || chk_code !== 15'd0) stale++;
    end
    n_chk++;
    if (stale !== 0) $display("FAIL stale_after_reset: got %0d bad cycles want 0", stale);
    else n_pass++;
  endtask

  task automatic test_zero_stride_tag();
    clear_tbl();
    blk_tbl[15'h0042] = 1'b1;
    run_edge(15'h0042, 15'h0000, 8'hA5, 0);
  endtask

  task automatic test_back_to_back();
    int first;
    clear_tbl();
    run_edge(15'h0200, 15'h0003, 8'h01, 0);
    first = accept_cyc;
    run_edge(15'h0300, 15'h0005, 8'h02, 0);
    n_chk++;
    if (accept_cyc - first !== NSAMP + 2)
      $display("FAIL back_to_back_gap: got %0d want %0d cycles", accept_cyc - first, NSAMP + 2);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [14:0] base, stride;
    int code;
    for (int n = 0; n < 20; n++) begin
      clear_tbl();
      base = 15'($urandom);
      case ($urandom_range(2))
        0: stride = 15'd0;
        1: stride = 15'd1;
        default: stride = 15'($urandom);
      endcase
      for (int i = 0; i < NSAMP; i++) begin
        code = (int'(base) + i * int'(stride)) % 32768;
        if ($urandom_range(5) == 0) blk_tbl[code] = 1'b1;
      end
      run_edge(base, stride, 8'($urandom), $urandom_range(3));
    end
  endtask

  initial begin
    test_reset();
    test_free_edge();
    test_blocked_edge();
    test_wrap();
    test_backpressure();
    test_reset_mid_scan();
    test_zero_stride_tag();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
